// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state register, round counter and
// round-key selection, and steps the shared SubBytes/ShiftRows/MixColumns units one per cycle.
module aes_encrypt_ctrl #(
    parameter int NR = 10
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    AES_START,
    input  logic [127:0]            AES_MSG_ENC,
    input  logic [128*(NR+1)-1:0]   Full_Roundkey,
    input  logic [127:0]            SUB_IN,
    input  logic [127:0]            SHIFT_IN,
    input  logic [127:0]            MIX_IN,
    output logic [127:0]            STATE_OUT,
    output logic [127:0]            CIPHERTEXT,
    output logic                    AES_DONE,
    output logic [1:0]              OP_SEL,
    output logic [3:0]              ROUND
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADDKEY,
        SUB,
        SHIFT,
        MIX,
        DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] roundKey;

    // Round r key sits at the top of the schedule for r=0 and walks down 128 bits per round.
    always_comb begin
        roundKey = '0;
        for (int i = 0; i <= NR; i++) begin
            if (round_q == 4'(i)) begin
                roundKey = Full_Roundkey[128*(NR-i) +: 128];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            data_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                round_d = '0;
                if (AES_START) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = AES_MSG_ENC;
                round_d = '0;
                state_d = ADDKEY;
            end
            ADDKEY: begin
                data_d = data_q ^ roundKey;
                if (round_q >= LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = SUB;
                end
            end
            SUB: begin
                data_d  = SUB_IN;
                state_d = SHIFT;
            end
            // The final round goes straight from ShiftRows to the last key addition.
            SHIFT: begin
                data_d  = SHIFT_IN;
                state_d = (round_q >= LAST_ROUND) ? ADDKEY : MIX;
            end
            MIX: begin
                data_d  = MIX_IN;
                state_d = ADDKEY;
            end
            DONE: begin
                if (!AES_START) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    always_comb begin
        OP_SEL = 2'b00;
        case (state_q)
            SUB:     OP_SEL = 2'b11;
            SHIFT:   OP_SEL = 2'b01;
            MIX:     OP_SEL = 2'b10;
            default: OP_SEL = 2'b00;
        endcase
    end

    assign AES_DONE   = (state_q == DONE);
    assign STATE_OUT  = data_q;
    assign CIPHERTEXT = data_q;
    assign ROUND      = round_q;

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Testbench for aes_encrypt_ctrl: provides the SubBytes/ShiftRows/MixColumns units and key
// schedule, drives FIPS-197 vectors and scoreboards each completed ciphertext.
module tb_aes_encrypt_ctrl;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            AES_START;
    logic [127:0]    AES_MSG_ENC;
    logic [1407:0]   Full_Roundkey;
    logic [127:0]    SUB_IN, SHIFT_IN, MIX_IN;
    logic [127:0]    STATE_OUT, CIPHERTEXT;
    logic            AES_DONE;
    logic [1:0]      OP_SEL;
    logic [3:0]      ROUND;

    int              checks = 0;
    int              errors = 0;
    logic [127:0]    expQ[$];
    logic [127:0]    expCt;
    logic            prevDone = 1'b0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_encrypt_ctrl #(.NR(10)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .AES_START(AES_START),
        .AES_MSG_ENC(AES_MSG_ENC),
        .Full_Roundkey(Full_Roundkey),
        .SUB_IN(SUB_IN),
        .SHIFT_IN(SHIFT_IN),
        .MIX_IN(MIX_IN),
        .STATE_OUT(STATE_OUT),
        .CIPHERTEXT(CIPHERTEXT),
        .AES_DONE(AES_DONE),
        .OP_SEL(OP_SEL),
        .ROUND(ROUND)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            r[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return r;
    endfunction

    function automatic logic [1407:0] keySchedule(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
        return ks;
    endfunction

    assign SUB_IN   = subBytes(STATE_OUT);
    assign SHIFT_IN = shiftRows(STATE_OUT);
    assign MIX_IN   = mixColumns(STATE_OUT);

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt,
                                 input logic [127:0] ct, input bit expectOutput);
        Full_Roundkey = keySchedule(key);
        AES_MSG_ENC   = pt;
        if (expectOutput) expQ.push_back(ct);
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        while (!AES_DONE && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        if (!AES_DONE) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no AES_DONE in %0d cycles, required AES_DONE=1", cyc);
        end
    endtask

    // Monitor: every rising AES_DONE must match the oldest outstanding expected ciphertext.
    always @(negedge CLK) begin
        if (AES_DONE && !prevDone) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got ciphertext %h, required no output", CIPHERTEXT);
            end else begin
                expCt = expQ.pop_front();
                checkOutput("ciphertext", CIPHERTEXT, expCt);
            end
        end
        prevDone <= AES_DONE;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] trace[$];
        logic [1:0] expTrace[$];
        int         cyc;
        int         doneCycle;
        int         badIdx;
        bit         heldOk;

        RESET         = 1'b1;
        AES_START     = 1'b0;
        AES_MSG_ENC   = '0;
        Full_Roundkey = '0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_state_out", STATE_OUT, 128'h0);
        checkOutput("reset_done", {127'h0, AES_DONE}, 128'h0);
        checkOutput("reset_round", {124'h0, ROUND}, 128'h0);
        checkOutput("reset_opsel", {126'h0, OP_SEL}, 128'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // C.1 with a one-cycle START pulse; cycle 0 is the IDLE cycle that samples START.
        expTrace = {2'b00, 2'b00};
        for (int r = 0; r < 9; r++) expTrace = {expTrace, 2'b11, 2'b01, 2'b10, 2'b00};
        expTrace = {expTrace, 2'b11, 2'b01, 2'b00};
        applyStimulus(KEY_C, PT_C, CT_C, 1'b1);
        AES_START = 1'b1;
        doneCycle = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (k == 1) AES_START = 1'b0;
            if (AES_DONE) begin
                doneCycle = k;
                break;
            end
            trace.push_back(OP_SEL);
        end
        checkOutput("done_latency", 128'(doneCycle), 128'd42);
        checks++;
        badIdx = -1;
        if (trace.size() != expTrace.size()) badIdx = trace.size();
        else for (int i = 0; i < trace.size(); i++) if (badIdx < 0 && trace[i] !== expTrace[i]) badIdx = i;
        if (badIdx >= 0) begin
            errors++;
            $display("[TB] FAIL opsel_trace: got divergence at entry %0d (length %0d), required length %0d matching 00,00,{11,01,10,00}x9,11,01,00",
                     badIdx, trace.size(), expTrace.size());
        end
        @(negedge CLK);
        checkOutput("pulse_done_one_cycle", {127'h0, AES_DONE}, 128'h0);
        checkOutput("idle_holds_state", STATE_OUT, CT_C);

        // Reset while ROUND=5 discards the run.
        applyStimulus(KEY_C, PT_C, CT_C, 1'b0);
        AES_START = 1'b1;
        cyc = 0;
        while (ROUND != 4'd5 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
        end
        checkOutput("reach_round5", {124'h0, ROUND}, 128'd5);
        RESET     = 1'b1;
        AES_START = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        checkOutput("midrun_reset_state_out", STATE_OUT, 128'h0);
        checkOutput("midrun_reset_done", {127'h0, AES_DONE}, 128'h0);
        checkOutput("midrun_reset_round", {124'h0, ROUND}, 128'h0);
        checkOutput("midrun_reset_opsel", {126'h0, OP_SEL}, 128'h0);
        @(negedge CLK);

        // App. B with START held through DONE for 100 cycles: no restart.
        applyStimulus(KEY_B, PT_B, CT_B, 1'b1);
        AES_START = 1'b1;
        waitDone(cyc);
        heldOk = 1'b1;
        repeat (100) begin
            @(negedge CLK);
            if (!AES_DONE || CIPHERTEXT !== CT_B) heldOk = 1'b0;
        end
        checkOutput("held_start_done_stable", {127'h0, heldOk}, 128'h1);
        AES_START = 1'b0;
        @(negedge CLK);
        checkOutput("idle_after_start_drop", {127'h0, AES_DONE}, 128'h0);

        // Back-to-back: START was low for exactly one cycle, now C.1.
        applyStimulus(KEY_C, PT_C, CT_C, 1'b1);
        AES_START = 1'b1;
        waitDone(cyc);
        AES_START = 1'b0;
        repeat (3) @(negedge CLK);

        checkOutput("scoreboard_drained", 128'(expQ.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_ctrl.md
Name: aes_encrypt_ctrl

Overview:
- Iterative AES-128 encryption sequencer. It is the forward-direction counterpart of the decryption controller.
- Owns the 128-bit state register, the round counter, round-key selection and the per-cycle operation select.
- Sequence: AddRoundKey, then 9 rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey, then a final round with no MixColumns.
- Sits between the AES top level (start/done handshake, key schedule from the key expansion block) and the shared combinational SubBytes, ShiftRows and MixColumns units.

Parameters:
- NR, 10, number of rounds. Only 10 is supported; the schedule width is 128*(NR+1) = 1408.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- AES_START  in  1  level request; sampled only in IDLE and DONE.
- AES_MSG_ENC  in  128  plaintext; must be stable from AES_START rising until the LOAD cycle.
- Full_Roundkey  in  1408  expanded schedule; round r key = bits [1407-128r : 1280-128r], so round 0 = [1407:1280] (cipher key) and round 10 = [127:0].
- SUB_IN  in  128  SubBytes(STATE_OUT) from the external unit.
- SHIFT_IN  in  128  ShiftRows(STATE_OUT).
- MIX_IN  in  128  MixColumns(STATE_OUT).
- STATE_OUT  out  128  current state register; feeds the three units.
- CIPHERTEXT  out  128  equals STATE_OUT; valid only while AES_DONE=1.
- AES_DONE  out  1  high only in DONE.
- OP_SEL  out  2  current operation: 00 addkey/idle, 01 shift, 10 mix, 11 sub.
- ROUND  out  4  current round counter.

Behaviour:
- Reset (RESET=1 at a CLK edge, any state): state=IDLE, state reg=0, ROUND=0, AES_DONE=0, OP_SEL=00. Reset takes priority over everything, including mid-encryption; the partial result is discarded.
- States: IDLE, LOAD, ADDKEY, SUB, SHIFT, MIX, DONE.
- IDLE:
  - AES_START=1 -> LOAD; else stay in IDLE.
  - State reg holds its value; ROUND=0.
- LOAD: state reg <= AES_MSG_ENC; ROUND <= 0; -> ADDKEY.
- ADDKEY: state reg <= state reg XOR key[ROUND].
  - ROUND=NR -> DONE.
  - Otherwise ROUND <= ROUND+1 -> SUB.
- SUB: state reg <= SUB_IN -> SHIFT.
- SHIFT: state reg <= SHIFT_IN.
  - ROUND=NR -> ADDKEY (final round skips MIX).
  - Otherwise -> MIX.
- MIX: state reg <= MIX_IN -> ADDKEY.
- DONE: state reg holds; AES_DONE=1.
  - AES_START=1 -> stay in DONE.
  - AES_START=0 -> IDLE.
- Latency: exactly 41 cycles in LOAD..final ADDKEY (LOAD 1 + ADDKEY0 1 + 9x4 + 3). AES_DONE first rises on the 42nd cycle after the IDLE cycle that sampled AES_START=1.
- Outputs:
  - AES_DONE, OP_SEL and STATE_OUT are decoded from registered state only, with no combinational path from inputs.
  - OP_SEL is 00 in IDLE, LOAD and DONE.
- AES_START deasserted mid-run: ignored; the run completes. DONE then lasts exactly one cycle before returning to IDLE.
- AES_START held high through DONE: no restart. A new run needs AES_START low for at least one cycle (passing through IDLE).
- Full_Roundkey is sampled combinationally in each ADDKEY cycle and must be stable for the whole run.
- ROUND never exceeds NR; an illegal state encoding recovers to IDLE on the next edge.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c schedule, AES_MSG_ENC=3243f6a8885a308d313198a2e0370734, AES_START held high.
  - Required: CIPHERTEXT=3925841d02dc09fbdc118597196a0b32 with AES_DONE=1; AES_DONE stays 1 until AES_START drops; IDLE one cycle after the drop.
- FIPS-197 App. C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: CIPHERTEXT=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Also check: AES_DONE rises exactly 42 cycles after the start-sampling edge, and the OP_SEL trace is 00,00,{11,01,10,00}x9,11,01,00.
- START pulse: AES_START high for 1 cycle only -> run completes, AES_DONE high for exactly 1 cycle, then IDLE, ciphertext still correct.
- Reset mid-run: assert RESET while ROUND=5 -> next cycle state=IDLE, STATE_OUT=0, AES_DONE=0, ROUND=0. A following App. B run is correct.
- Back-to-back: App. B run, AES_START low 1 cycle, then C.1 run -> both ciphertexts correct and no carry-over of the state register.
- Held START after DONE: keep AES_START=1 for 100 cycles in DONE -> no new LOAD, CIPHERTEXT unchanged.
